// File: rtl/fb_pkg.sv
// Shared framebuffer constants, pixel formats and the sideband record for fb_read_pipe.
// FB_READ_PIPE_BORDER_EN adds a border flag to the sideband record.
package fb_pkg;

   localparam int FB_WIDTH      = 320;
   localparam int FB_HEIGHT     = 180;
   localparam int FB_DEPTH      = FB_WIDTH * FB_HEIGHT;
   localparam int FB_ADDR_WIDTH = 16;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   // Everything that must stay cycle-aligned with the BRAM access.
   typedef struct packed {
      logic in_range;
`ifdef FB_READ_PIPE_BORDER_EN
      logic border;
`endif
      logic hsync;
      logic vsync;
      logic blank;
   } sideband_t;

`ifdef FB_READ_PIPE_BORDER_EN
   localparam sideband_t SIDEBAND_RST =
      '{in_range: 1'b0, border: 1'b0, hsync: 1'b0, vsync: 1'b0, blank: 1'b1};
`else
   localparam sideband_t SIDEBAND_RST =
      '{in_range: 1'b0, hsync: 1'b0, vsync: 1'b0, blank: 1'b1};
`endif

   localparam rgb888_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
   localparam rgb888_t RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

   // Replicate the top bits into the low bits so full scale maps to 8'hFF.
   function automatic rgb888_t expand_565(input rgb565_t p);
      rgb888_t o;
      o.r = {p.r, p.r[4:2]};
      o.g = {p.g, p.g[5:4]};
      o.b = {p.b, p.b[4:2]};
      return o;
   endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with a synchronous active-low flush to RESET_VALUE.
module sig_delay #(
   parameter int               WIDTH       = 1,
   parameter int               DEPTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stages [DEPTH];

   // NOTE: every stage is reset, not just the last, so no stale sideband leaks out after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VALUE;
      end else begin
         stages[0] <= d;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/fb_read_pipe.sv
// Scaled (h,v) -> framebuffer read address, RGB565 capture and RGB888 expansion, with sync delay.
// FB_READ_PIPE_BORDER_EN forces in-range framebuffer edge pixels to white.
module fb_read_pipe
   import fb_pkg::*;
#(
   parameter int FB_WIDTH     = fb_pkg::FB_WIDTH,
   parameter int FB_HEIGHT    = fb_pkg::FB_HEIGHT,
   parameter int ADDR_WIDTH   = fb_pkg::FB_ADDR_WIDTH,
   parameter int BRAM_LATENCY = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [10:0]           scaled_hcount_in,
   input  logic [9:0]            scaled_vcount_in,
   input  logic                  valid_addr_in,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic                  blank_in,
   output logic [ADDR_WIDTH-1:0] fb_addr_out,
   output logic                  fb_rd_en_out,
   input  logic [15:0]           fb_data_in,
   output logic [7:0]            red_out,
   output logic [7:0]            green_out,
   output logic [7:0]            blue_out,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic                  blank_out,
   output logic [15:0]           frame_count_out
);

   localparam logic [10:0] H_LIMIT = 11'(FB_WIDTH);
   localparam logic [9:0]  V_LIMIT = 10'(FB_HEIGHT);

   logic                  in_range;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [ADDR_WIDTH-1:0] addr_next;
   sideband_t             sb_next;
   sideband_t             sb_s0;
   sideband_t             sb_d;
   rgb888_t               pix_next;
   logic                  vsync_rise;
   logic [15:0]           frame_count_q;

   assign in_range = valid_addr_in && (scaled_hcount_in < H_LIMIT) && (scaled_vcount_in < V_LIMIT);

   // 320 = 256 + 64, so the row base is two shifts and an add.
   if (FB_WIDTH == 320) begin : g_row_shift
      assign row_base = (ADDR_WIDTH'(scaled_vcount_in) << 8) + (ADDR_WIDTH'(scaled_vcount_in) << 6);
   end else begin : g_row_mul
      assign row_base = ADDR_WIDTH'(scaled_vcount_in * FB_WIDTH);
   end

   assign addr_next = in_range ? row_base + ADDR_WIDTH'(scaled_hcount_in) : '0;

   // NOTE: every field gets a value on every path, so this stays combinational with no latch.
   always_comb begin
      sb_next          = SIDEBAND_RST;
      sb_next.in_range = in_range;
`ifdef FB_READ_PIPE_BORDER_EN
      sb_next.border   = (scaled_hcount_in == 11'd0) || (scaled_hcount_in == H_LIMIT - 11'd1) ||
                         (scaled_vcount_in == 10'd0) || (scaled_vcount_in == V_LIMIT - 10'd1);
`endif
      sb_next.hsync    = hsync_in;
      sb_next.vsync    = vsync_in;
      sb_next.blank    = blank_in;
   end

   // NOTE: state is updated with <= so every register samples pre-edge values regardless of order.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         fb_addr_out  <= '0;
         fb_rd_en_out <= 1'b0;
         sb_s0        <= SIDEBAND_RST;
      end else begin
         fb_addr_out  <= addr_next;
         fb_rd_en_out <= in_range;
         sb_s0        <= sb_next;
      end
   end

   sig_delay #(
      .WIDTH       ($bits(sideband_t)),
      .DEPTH       (BRAM_LATENCY),
      .RESET_VALUE (SIDEBAND_RST)
   ) u_sideband_delay (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .d     (sb_s0),
      .q     (sb_d)
   );

   always_comb begin
      pix_next = RGB_BLACK;
      if (sb_d.in_range) begin
         pix_next = expand_565(rgb565_t'(fb_data_in));
`ifdef FB_READ_PIPE_BORDER_EN
         if (sb_d.border) pix_next = RGB_WHITE;
`endif
      end
   end

   // vsync_out is the registered copy of sb_d.vsync, so this is the delayed-vsync rising edge.
   assign vsync_rise = sb_d.vsync && !vsync_out;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         red_out       <= 8'h00;
         green_out     <= 8'h00;
         blue_out      <= 8'h00;
         hsync_out     <= 1'b0;
         vsync_out     <= 1'b0;
         blank_out     <= 1'b1;
         frame_count_q <= 16'h0000;
      end else begin
         red_out   <= pix_next.r;
         green_out <= pix_next.g;
         blue_out  <= pix_next.b;
         hsync_out <= sb_d.hsync;
         vsync_out <= sb_d.vsync;
         blank_out <= sb_d.blank;
         if (vsync_rise) frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_fb_read_pipe.sv
// Directed bench for fb_read_pipe with a two-cycle BRAM model; build with FB_READ_PIPE_BORDER_EN to cover the border.
module tb_fb_read_pipe;
   import fb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] scaled_h;
   logic [9:0]  scaled_v;
   logic        valid;
   logic        hs, vs, bl;
   logic [15:0] fb_addr;
   logic        fb_rd_en;
   logic [15:0] fb_data;
   logic [7:0]  red, green, blue;
   logic        hsync_o, vsync_o, blank_o;
   logic [15:0] frame_count;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [FB_DEPTH];
   logic [15:0] rd_addr_q;

   always #5 clk = ~clk;

   // Address registered, then data registered: valid two cycles after fb_addr_out.
   always @(posedge clk) begin
      rd_addr_q <= fb_addr;
      fb_data   <= mem[rd_addr_q];
   end

   fb_read_pipe dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .scaled_hcount_in (scaled_h),
      .scaled_vcount_in (scaled_v),
      .valid_addr_in    (valid),
      .hsync_in         (hs),
      .vsync_in         (vs),
      .blank_in         (bl),
      .fb_addr_out      (fb_addr),
      .fb_rd_en_out     (fb_rd_en),
      .fb_data_in       (fb_data),
      .red_out          (red),
      .green_out        (green),
      .blue_out         (blue),
      .hsync_out        (hsync_o),
      .vsync_out        (vsync_o),
      .blank_out        (blank_o),
      .frame_count_out  (frame_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_rgb(input string tag, input logic [23:0] exp);
      check(tag, {8'h00, red, green, blue}, {8'h00, exp});
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input int h, input int v, input logic va, input logic h_s, input logic v_s,
                        input logic b);
      scaled_h = 11'(h);
      scaled_v = 10'(v);
      valid    = va;
      hs       = h_s;
      vs       = v_s;
      bl       = b;
   endtask

   task automatic idle();
      drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < FB_DEPTH; i++) mem[i] = 16'h0000;
      mem[0]     = 16'hFFFF;  // read by out-of-range cycles; must never reach the pixel
      mem[321]   = 16'hF800;
      mem[57599] = 16'h07E0;
      mem[32100] = 16'h8410;

      rst_n = 1'b0;
      idle();
      repeat (3) step();
      check("rst_addr", 32'(fb_addr), 32'd0);
      check("rst_rd_en", 32'(fb_rd_en), 32'd0);
      check_rgb("rst_rgb", 24'h000000);
      check("rst_syncs", {29'd0, hsync_o, vsync_o, blank_o}, 32'b001);
      check("rst_frames", 32'(frame_count), 32'd0);

      rst_n = 1'b1;
      step();

      // Address stage and pixel expansion, 4-cycle latency.
      drive(1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("addr_1_1", 32'(fb_addr), 32'd321);
      check("rd_en_1_1", 32'(fb_rd_en), 32'd1);
      drive(319, 179, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("addr_319_179", 32'(fb_addr), 32'd57599);
      check("rd_en_319_179", 32'(fb_rd_en), 32'd1);
      drive(10, 10, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check("addr_invalid", 32'(fb_addr), 32'd0);
      check("rd_en_invalid", 32'(fb_rd_en), 32'd0);
      drive(320, 5, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("addr_h320", 32'(fb_addr), 32'd0);
      check("rd_en_h320", 32'(fb_rd_en), 32'd0);
      check_rgb("rgb_red", 24'hFF0000);
      check("blank_red", 32'(blank_o), 32'd0);
      drive(100, 100, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
`ifdef FB_READ_PIPE_BORDER_EN
      check_rgb("rgb_corner_border", 24'hFFFFFF);
`else
      check_rgb("rgb_green", 24'h00FF00);
`endif
      check("blank_green", 32'(blank_o), 32'd0);
      idle();
      step();
      check_rgb("rgb_invalid_black", 24'h000000);
      check("blank_invalid", 32'(blank_o), 32'd0);
      step();
      check_rgb("rgb_h320_black", 24'h000000);
      step();
      check_rgb("rgb_mixed", 24'h848284);
      step();
      check("blank_idle", 32'(blank_o), 32'd1);

      // Left edge vs interior pixel, both reading zero data.
      drive(0, 50, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(5, 50, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      idle();
      step();
      step();
`ifdef FB_READ_PIPE_BORDER_EN
      check_rgb("rgb_edge_0_50", 24'hFFFFFF);
`else
      check_rgb("rgb_edge_0_50", 24'h000000);
`endif
      step();
      check_rgb("rgb_inner_5_50", 24'h000000);

      // One-cycle hsync pulse emerges exactly four cycles later.
      drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      idle();
      step();
      step();
      check("hsync_n3", 32'(hsync_o), 32'd0);
      step();
      check("hsync_n4", 32'(hsync_o), 32'd1);
      step();
      check("hsync_n5", 32'(hsync_o), 32'd0);

      // Three vsync rising edges.
      for (int p = 0; p < 3; p++) begin
         drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
         step();
         idle();
         step();
         step();
      end
      repeat (5) step();
      check("frames_3", 32'(frame_count), 32'd3);

      // Wrap from 0xFFFF.
      force dut.frame_count_q = 16'hFFFF;
      step();
      release dut.frame_count_q;
      step();
      check("frames_preload", 32'(frame_count), 32'hFFFF);
      drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      idle();
      repeat (6) step();
      check("frames_wrap", 32'(frame_count), 32'd0);

      // One-cycle reset during active video.
      drive(1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) step();
      check_rgb("rgb_before_reset", 24'hFF0000);
      rst_n = 1'b0;
      step();
      check("blank_in_reset", 32'(blank_o), 32'd1);
      check_rgb("rgb_in_reset", 24'h000000);
      check("rd_en_in_reset", 32'(fb_rd_en), 32'd0);
      rst_n = 1'b1;
      repeat (3) step();
      check("blank_flushed", 32'(blank_o), 32'd1);
      check_rgb("rgb_flushed", 24'h000000);
      step();
      check("blank_resumed", 32'(blank_o), 32'd0);
      check_rgb("rgb_resumed", 24'hFF0000);

      idle();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
